ddr3_axi_arbiter: RTL and testbench

DDR3_AXI_ARBITER -- requirements
Module: ddr3_axi_arbiter

---
 rtl/ddr3_arb_pkg.sv | 21 ++
 rtl/rr_arbiter4.sv | 31 +++
 rtl/ddr3_axi_arbiter.sv | 151 +++++++++++++++
 tb/tb_ddr3_axi_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg: shared types and constants for the DDR3 AXI burst arbiter.
//   state_e        - arbiter FSM states (IDLE, AW, W, AR, R)
//   SRC_WR0..RD1   - request source indices (writers 0/1, readers 2/3)
//   BURST_BEATS_DEF- default beats per burst
package ddr3_arb_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_AW, ST_W, ST_AR, ST_R
  } state_e;

  localparam int BURST_BEATS_DEF = 16;

  localparam logic [1:0] SRC_WR0 = 2'd0;
  localparam logic [1:0] SRC_WR1 = 2'd1;
  localparam logic [1:0] SRC_RD0 = 2'd2;
  localparam logic [1:0] SRC_RD1 = 2'd3;

  // Sources 0/1 are writers, 2/3 are readers.
  function automatic logic is_write_src(input logic [1:0] s);
    return !s[1];
  endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin pick.
//   req_i     - request vector
//   ptr_i     - highest-priority index this round
//   gnt_oh_o  - one-hot grant (all zero when no request)
//   gnt_idx_o - index of the granted source (ptr_i when no request)
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_oh_o,
  output logic [1:0] gnt_idx_o
);
  logic [1:0] idx;
  logic       hit;

  // Walk offsets from farthest to nearest so the nearest set bit
  // at or after ptr_i is the one left standing.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = ptr_i;
    idx       = '0;
    hit       = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_i + 2'(k);
      if (req_i[idx]) begin
        gnt_idx_o = idx;
        hit       = 1'b1;
      end
    end
    if (hit) gnt_oh_o[gnt_idx_o] = 1'b1;
  end
endmodule

// File: rtl/ddr3_axi_arbiter.sv
// ddr3_axi_arbiter: round-robin arbiter of two write and two read burst
// sources onto one AXI port of a DDR3 controller, one burst in flight.
//   core_clk, i_rst_n        - clock, synchronous active-low reset
//   ddr_init_done            - gates new grants only
//   req_valid/req_addr/req_ready - per-source burst requests
//   wr_data/wr_data_req      - writer beat data and per-beat consume strobe
//   rd_data/rd_valid/rd_last - read data broadcast, per-reader strobes
//   axi_aw*/axi_w*/axi_ar*/axi_r* - AXI master side
//   busy, grant_id, stat_cnt - status
// Optional build macro ARB_STATS_EN: per-source saturating burst counters
// on stat_cnt; without it stat_cnt is tied to zero.
module ddr3_axi_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 256,
  parameter int BURST_BEATS = BURST_BEATS_DEF
) (
  input  logic                   core_clk,
  input  logic                   i_rst_n,
  input  logic                   ddr_init_done,
  input  logic [3:0]             req_valid,
  input  logic [3:0][ADDR_W-1:0] req_addr,
  output logic [3:0]             req_ready,
  input  logic [1:0][DATA_W-1:0] wr_data,
  output logic [1:0]             wr_data_req,
  output logic [DATA_W-1:0]      rd_data,
  output logic [1:0]             rd_valid,
  output logic [1:0]             rd_last,
  output logic [ADDR_W-1:0]      axi_awaddr,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [DATA_W-1:0]      axi_wdata,
  input  logic                   axi_wready,
  output logic [ADDR_W-1:0]      axi_araddr,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic [DATA_W-1:0]      axi_rdata,
  input  logic                   axi_rvalid,
  input  logic                   axi_rlast,
  output logic [3:0]             axi_awlen,
  output logic [3:0]             axi_arlen,
  output logic                   busy,
  output logic [1:0]             grant_id,
  output logic [3:0][15:0]       stat_cnt
);
  localparam int CNT_W = $clog2(BURST_BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

  state_e              state_q;
  logic [1:0]          owner_q, rr_ptr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    beat_q;
  logic                awvalid_q, arvalid_q;

  logic [3:0] gnt_oh;
  logic [1:0] gnt_idx;
  logic       wr_beat, wr_done, rd_done;

  rr_arbiter4 u_rr (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  assign wr_beat = (state_q == ST_W) && axi_wready;
  assign wr_done = wr_beat && (beat_q == LAST_BEAT);
  assign rd_done = (state_q == ST_R) && axi_rvalid && axi_rlast;

  always_ff @(posedge core_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      addr_q    <= '0;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (ddr_init_done && |gnt_oh) begin
          owner_q  <= gnt_idx;
          rr_ptr_q <= gnt_idx + 2'd1;
          addr_q   <= req_addr[gnt_idx];
          beat_q   <= '0;
          if (is_write_src(gnt_idx)) begin
            state_q   <= ST_AW;
            awvalid_q <= 1'b1;
          end else begin
            state_q   <= ST_AR;
            arvalid_q <= 1'b1;
          end
        end
        ST_AW: if (axi_awready) begin
          awvalid_q <= 1'b0;
          state_q   <= ST_W;
        end
        ST_W: if (wr_beat) begin
          beat_q <= beat_q + 1'b1;
          if (wr_done) state_q <= ST_IDLE;
        end
        ST_AR: if (axi_arready) begin
          arvalid_q <= 1'b0;
          state_q   <= ST_R;
        end
        ST_R: if (rd_done) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake strobes follow the AXI ready combinationally so the pulse
  // lands in the address handshake cycle itself.
  always_comb begin
    req_ready   = '0;
    wr_data_req = '0;
    rd_valid    = '0;
    rd_last     = '0;
    if ((state_q == ST_AW && axi_awready) || (state_q == ST_AR && axi_arready))
      req_ready[owner_q] = 1'b1;
    if (wr_beat) wr_data_req[owner_q[0]] = 1'b1;
    if (state_q == ST_R) begin
      rd_valid[owner_q[0]] = axi_rvalid;
      rd_last[owner_q[0]]  = axi_rvalid & axi_rlast;
    end
  end

  assign axi_awaddr  = addr_q;
  assign axi_araddr  = addr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_arvalid = arvalid_q;
  assign axi_wdata   = wr_data[owner_q[0]];
  assign rd_data     = axi_rdata;
  assign axi_awlen   = 4'(BURST_BEATS - 1);
  assign axi_arlen   = 4'(BURST_BEATS - 1);
  assign busy        = (state_q != ST_IDLE);
  assign grant_id    = owner_q;

`ifdef ARB_STATS_EN
  logic [3:0][15:0] stat_q;
  always_ff @(posedge core_clk) begin
    if (!i_rst_n) stat_q <= '0;
    else if ((wr_done || rd_done) && stat_q[owner_q] != 16'hFFFF)
      stat_q[owner_q] <= stat_q[owner_q] + 16'd1;
  end
  assign stat_cnt = stat_q;
`else
  assign stat_cnt = '0;
`endif
endmodule

// File: tb/tb_ddr3_axi_arbiter.sv
// tb_ddr3_axi_arbiter: scenario bench for ddr3_axi_arbiter. Expected grants
// (source, address) are queued when requests are raised and popped when the
// DUT presents the address; a burst-count model tracks completed bursts.
module tb_ddr3_axi_arbiter;
  import ddr3_arb_pkg::*;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;
  localparam int BB     = 16;

  logic core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  logic                   i_rst_n, ddr_init_done;
  logic [3:0]             req_valid, req_ready;
  logic [3:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] wr_data;
  logic [1:0]             wr_data_req, rd_valid, rd_last;
  logic [DATA_W-1:0]      rd_data, axi_wdata, axi_rdata;
  logic [ADDR_W-1:0]      axi_awaddr, axi_araddr;
  logic                   axi_awvalid, axi_awready, axi_wready;
  logic                   axi_arvalid, axi_arready, axi_rvalid, axi_rlast;
  logic [3:0]             axi_awlen, axi_arlen;
  logic                   busy;
  logic [1:0]             grant_id;
  logic [3:0][15:0]       stat_cnt;

  ddr3_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_BEATS(BB)) dut (
    .core_clk(core_clk), .i_rst_n(i_rst_n), .ddr_init_done(ddr_init_done),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .wr_data(wr_data), .wr_data_req(wr_data_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wready(axi_wready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast),
    .axi_awlen(axi_awlen), .axi_arlen(axi_arlen),
    .busy(busy), .grant_id(grant_id), .stat_cnt(stat_cnt)
  );

  typedef struct { int src; logic [ADDR_W-1:0] addr; } exp_t;
  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   stat_model[4];

  // burst observations returned by serve_burst
  int                src_o, lat_o, pulses_o, beats_o, bad_o;
  logic [ADDR_W-1:0] addr_o;
  logic              busy_o;
  bit                tmo_o;

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_exp(input int s);
    exp_t e;
    e.src = s; e.addr = req_addr[s];
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge core_clk);
    i_rst_n = 1'b0; req_valid = '0; axi_awready = 0; axi_arready = 0;
    axi_wready = 0; axi_rvalid = 0; axi_rlast = 0;
    repeat (2) @(negedge core_clk);
    i_rst_n = 1'b1; ddr_init_done = 1'b1;
    for (int i = 0; i < 4; i++) stat_model[i] = 0;
  endtask

  // Plays the AXI slave for one burst and reports what it saw.
  task automatic serve_burst(input int aw_delay, input int gap_mod, input bit drop,
                             output int src, output logic [ADDR_W-1:0] addr,
                             output int lat, output int pulses, output int beats,
                             output int bad, output logic busy_after, output bit tmo);
    bit         is_wr, beat;
    int         n, cyc;
    logic [1:0] ev;
    tmo = 0; lat = 0; pulses = 0; beats = 0; bad = 0; src = 0; addr = '0; busy_after = 1'b1;
    do begin @(negedge core_clk); lat++; #1; end
    while (!(axi_awvalid || axi_arvalid) && lat < 40);
    if (!(axi_awvalid || axi_arvalid)) begin tmo = 1; return; end
    is_wr = axi_awvalid;
    src   = int'(grant_id);
    addr  = is_wr ? axi_awaddr : axi_araddr;
    if (drop) req_valid = '0;
    for (int d = 0; d < aw_delay; d++) begin
      pulses += $countones(req_ready);
      @(negedge core_clk); #1;
      if ((is_wr ? axi_awaddr : axi_araddr) !== addr) bad++;
      if ((is_wr ? axi_awvalid : axi_arvalid) !== 1'b1) bad++;
    end
    if (is_wr) axi_awready = 1'b1; else axi_arready = 1'b1;
    #1;
    pulses += $countones(req_ready);
    if (req_ready !== 4'(1 << src)) bad++;
    @(negedge core_clk);
    axi_awready = 0; axi_arready = 0;
    #1;
    pulses += $countones(req_ready);
    n = 0; cyc = 0;
    while (n < BB && cyc < 200) begin
      beat = (gap_mod == 0) || (cyc % gap_mod != gap_mod - 1);
      if (is_wr) begin
        axi_wready = beat; wr_data[0] = rnd_data(); wr_data[1] = rnd_data();
        #1;
        if (axi_wdata !== wr_data[src[0]]) bad++;
        if (wr_data_req !== (beat ? 2'(1 << src) : 2'b00)) bad++;
        if (rd_valid !== 2'b00 || rd_last !== 2'b00) bad++;
        if (wr_data_req[src[0]]) beats++;
      end else begin
        axi_rvalid = beat; axi_rlast = beat && (n == BB - 1); axi_rdata = rnd_data();
        #1;
        ev = beat ? 2'(1 << (src - 2)) : 2'b00;
        if (rd_valid !== ev) bad++;
        if (rd_last !== (axi_rlast ? ev : 2'b00)) bad++;
        if (rd_data !== axi_rdata) bad++;
        if (wr_data_req !== 2'b00) bad++;
        if (rd_valid[src[0]]) beats++;
      end
      pulses += $countones(req_ready);
      if (beat) n++;
      cyc++;
      @(negedge core_clk); #1;
    end
    if (n < BB) tmo = 1;
    axi_wready = 0; axi_rvalid = 0; axi_rlast = 0;
    #1;
    busy_after = busy;
  endtask

  task automatic test_reset();
    @(negedge core_clk);
    i_rst_n = 0; ddr_init_done = 1; req_valid = 4'hF;
    repeat (2) @(negedge core_clk);
    #1;
    checks++; if ({busy, axi_awvalid, axi_arvalid} !== 3'b000) begin errors++;
      $display("FAIL reset_valids: got %b required 000", {busy, axi_awvalid, axi_arvalid}); end
    checks++; if (req_ready !== 4'h0 || grant_id !== 2'd0) begin errors++;
      $display("FAIL reset_ready_grant: got %h/%0d required 0/0", req_ready, grant_id); end
    checks++; if (stat_cnt !== '0) begin errors++;
      $display("FAIL reset_stat: got %h required 0", stat_cnt); end
    checks++; if (axi_awlen !== 4'd15 || axi_arlen !== 4'd15) begin errors++;
      $display("FAIL burst_len: got %0d/%0d required 15/15", axi_awlen, axi_arlen); end
    i_rst_n = 1; req_valid = '0;
    for (int i = 0; i < 4; i++) stat_model[i] = 0;
  endtask

  task automatic test_single_write();
    exp_t e;
    @(negedge core_clk);
    req_addr[0] = 28'h0000080; req_valid = 4'b0001; push_exp(0);
    serve_burst(2, 0, 1, src_o, addr_o, lat_o, pulses_o, beats_o, bad_o, busy_o, tmo_o);
    e = exp_q.pop_front();
    checks++; if (tmo_o) begin errors++; $display("FAIL c1_timeout: got timeout required completion"); end
    checks++; if (addr_o !== e.addr || src_o !== e.src) begin errors++;
      $display("FAIL c1_awaddr: got %h/%0d required %h/%0d", addr_o, src_o, e.addr, e.src); end
    checks++; if (lat_o !== 1) begin errors++; $display("FAIL c1_latency: got %0d required 1", lat_o); end
    checks++; if (pulses_o !== 1) begin errors++; $display("FAIL c1_req_ready: got %0d pulses required 1", pulses_o); end
    checks++; if (beats_o !== BB) begin errors++; $display("FAIL c1_wdata_req: got %0d required %0d", beats_o, BB); end
    checks++; if (bad_o !== 0) begin errors++; $display("FAIL c1_beats: got %0d bad cycles required 0", bad_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL c1_idle: got busy %b required 0", busy_o); end
    stat_model[e.src]++;
  endtask

  task automatic test_round_robin();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 4; i++) req_addr[i] = ADDR_W'(32'h100 * (i + 1));
    @(negedge core_clk);
    req_valid = 4'b1111;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    for (int k = 0; k < 5; k++) begin
      serve_burst(k % 2, 3, k == 4, src_o, addr_o, lat_o, pulses_o, beats_o, bad_o, busy_o, tmo_o);
      e = exp_q.pop_front();
      checks++; if (tmo_o || src_o !== e.src || addr_o !== e.addr) begin errors++;
        $display("FAIL c2_grant%0d: got src %0d addr %h tmo %0d required src %0d addr %h",
                 k, src_o, addr_o, tmo_o, e.src, e.addr); end
      checks++; if (lat_o !== 1 || pulses_o !== 1 || beats_o !== BB || bad_o !== 0) begin errors++;
        $display("FAIL c2_burst%0d: got lat %0d pulses %0d beats %0d bad %0d required 1/1/%0d/0",
                 k, lat_o, pulses_o, beats_o, bad_o, BB); end
      stat_model[e.src]++;
    end
  endtask

  task automatic test_read_gaps();
    exp_t e;
    @(negedge core_clk);
    req_addr[3] = 28'hFFFFF80; req_valid = 4'b1000; push_exp(3);
    serve_burst(1, 3, 1, src_o, addr_o, lat_o, pulses_o, beats_o, bad_o, busy_o, tmo_o);
    e = exp_q.pop_front();
    checks++; if (tmo_o || src_o !== e.src || addr_o !== e.addr) begin errors++;
      $display("FAIL c3_araddr: got %0d/%h required %0d/%h", src_o, addr_o, e.src, e.addr); end
    checks++; if (beats_o !== BB || bad_o !== 0) begin errors++;
      $display("FAIL c3_rd_mirror: got beats %0d bad %0d required %0d/0", beats_o, bad_o, BB); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL c3_idle: got busy %b required 0", busy_o); end
    stat_model[e.src]++;
  endtask

  task automatic test_init_gate();
    exp_t e;
    int   bad = 0;
    @(negedge core_clk);
    ddr_init_done = 0; req_addr[2] = 28'h0ABCDE0; req_valid = 4'b0100; push_exp(2);
    repeat (5) begin
      @(negedge core_clk); #1;
      if (axi_arvalid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL c4_gated: got %0d active cycles required 0", bad); end
    ddr_init_done = 1;
    @(negedge core_clk); #1;
    checks++; if (axi_arvalid !== 1'b1) begin errors++; $display("FAIL c4_arvalid: got %b required 1", axi_arvalid); end
    serve_burst(0, 0, 1, src_o, addr_o, lat_o, pulses_o, beats_o, bad_o, busy_o, tmo_o);
    e = exp_q.pop_front();
    checks++; if (tmo_o || src_o !== e.src || addr_o !== e.addr || bad_o !== 0) begin errors++;
      $display("FAIL c4_burst: got %0d/%h bad %0d required %0d/%h", src_o, addr_o, bad_o, e.src, e.addr); end
    stat_model[e.src]++;
  endtask

  task automatic test_init_drop();
    exp_t e;
    int   bad = 0;
    @(negedge core_clk);
    req_addr[0] = 28'h0001000; req_addr[1] = 28'h0002000; req_valid = 4'b0011;
    push_exp(0); push_exp(1);
    @(negedge core_clk); #1;
    ddr_init_done = 0;
    serve_burst(1, 0, 0, src_o, addr_o, lat_o, pulses_o, beats_o, bad_o, busy_o, tmo_o);
    e = exp_q.pop_front();
    checks++; if (tmo_o || src_o !== e.src || addr_o !== e.addr || beats_o !== BB) begin errors++;
      $display("FAIL initdrop_wrap: got src %0d beats %0d required src %0d beats %0d", src_o, beats_o, e.src, BB); end
    stat_model[e.src]++;
    repeat (4) begin
      @(negedge core_clk); #1;
      if (busy !== 1'b0 || axi_awvalid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL initdrop_nogrant: got %0d active cycles required 0", bad); end
    ddr_init_done = 1;
    serve_burst(0, 2, 1, src_o, addr_o, lat_o, pulses_o, beats_o, bad_o, busy_o, tmo_o);
    e = exp_q.pop_front();
    checks++; if (tmo_o || src_o !== e.src || addr_o !== e.addr || lat_o !== 1 || bad_o !== 0) begin errors++;
      $display("FAIL initdrop_resume: got src %0d lat %0d bad %0d required src %0d lat 1", src_o, lat_o, bad_o, e.src); end
    stat_model[e.src]++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge core_clk);
    req_addr[0] = 28'h0003000; req_valid = 4'b0001;
    @(negedge core_clk); #1;
    checks++; if (axi_awvalid !== 1'b1) begin errors++; $display("FAIL c5_awvalid: got %b required 1", axi_awvalid); end
    req_valid = '0; axi_awready = 1;
    @(negedge core_clk);
    axi_awready = 0;
    for (int k = 0; k < 7; k++) begin
      axi_wready = 1; wr_data[0] = rnd_data();
      @(negedge core_clk);
    end
    axi_wready = 1; i_rst_n = 0;
    @(negedge core_clk);
    axi_wready = 0;
    #1;
    checks++; if ({busy, axi_awvalid, axi_arvalid, wr_data_req, req_ready, grant_id} !== '0) begin errors++;
      $display("FAIL c5_abandon: got busy %b aw %b ar %b wreq %b rdy %b gid %0d required all 0",
               busy, axi_awvalid, axi_arvalid, wr_data_req, req_ready, grant_id); end
    checks++; if (stat_cnt !== '0) begin errors++; $display("FAIL c5_stat: got %h required 0", stat_cnt); end
    i_rst_n = 1;
    for (int i = 0; i < 4; i++) stat_model[i] = 0;
    req_addr[1] = 28'h0004440; req_addr[2] = 28'h0005550; req_valid = 4'b0110; push_exp(1);
    serve_burst(1, 0, 1, src_o, addr_o, lat_o, pulses_o, beats_o, bad_o, busy_o, tmo_o);
    e = exp_q.pop_front();
    checks++; if (tmo_o || src_o !== e.src || addr_o !== e.addr || bad_o !== 0 || busy_o !== 1'b0) begin errors++;
      $display("FAIL c5_regrant: got src %0d addr %h bad %0d required src %0d addr %h", src_o, addr_o, bad_o, e.src, e.addr); end
    stat_model[e.src]++;
  endtask

  task automatic test_stats();
    exp_t e;
    int   ex;
    apply_reset();
    req_addr[1] = 28'h0007700;
    for (int k = 0; k < 3; k++) begin
      @(negedge core_clk);
      req_valid = 4'b0010; push_exp(1);
      serve_burst(0, 0, 1, src_o, addr_o, lat_o, pulses_o, beats_o, bad_o, busy_o, tmo_o);
      e = exp_q.pop_front();
      checks++; if (tmo_o || src_o !== e.src || beats_o !== BB) begin errors++;
        $display("FAIL c6_burst%0d: got src %0d beats %0d required src %0d beats %0d", k, src_o, beats_o, e.src, BB); end
      stat_model[e.src]++;
    end
    @(negedge core_clk); #1;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_STATS_EN
      ex = stat_model[i];
`else
      ex = 0;
`endif
      checks++; if (stat_cnt[i] !== 16'(ex)) begin errors++;
        $display("FAIL c6_stat%0d: got %0d required %0d", i, stat_cnt[i], ex); end
    end
  endtask

  initial begin
    i_rst_n = 0; ddr_init_done = 0; req_valid = '0; req_addr = '0; wr_data = '0;
    axi_awready = 0; axi_wready = 0; axi_arready = 0; axi_rdata = '0;
    axi_rvalid = 0; axi_rlast = 0;
    for (int i = 0; i < 4; i++) stat_model[i] = 0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_gaps();
    test_init_gate();
    test_init_drop();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish before 500us");
    $fatal(1);
  end
endmodule
